// File: rtl/skew_ctrl_pkg.sv
// Shared types and helpers for the skew-buffer load/stream controller.
package skew_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  // A tile of N rows drains through the skew buffer in 2N-1 shifts.
  function automatic int unsigned stream_len(input int unsigned array_size);
    return 2 * array_size - 1;
  endfunction

endpackage

// File: rtl/skew_load_controller.sv
// Loads one A-matrix tile row by row into the skew buffer, then streams the
// skewed columns out under downstream backpressure and pulses done.
module skew_load_controller
  import skew_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          buf_write,
  output logic [$clog2(ARRAY_SIZE)-1:0] buf_row_ptr,
  output logic                          buf_enable,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          done,
  output logic                          busy
);

  localparam int unsigned PTR_W  = $clog2(ARRAY_SIZE);
  localparam int unsigned ROW_W  = PTR_W + 1;
  localparam int unsigned SCNT_W = $clog2(2 * ARRAY_SIZE);
  localparam int unsigned SLEN   = stream_len(ARRAY_SIZE);

  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ARRAY_SIZE - 1);
  localparam logic [SCNT_W-1:0] STREAM_LAST = SCNT_W'(SLEN - 1);

  if (ARRAY_SIZE < 2 || DATA_WIDTH == 0) begin : g_param_check
    $error("skew_load_controller: ARRAY_SIZE must be >= 2 and DATA_WIDTH > 0");
  end

  state_t              state;
  logic [ROW_W-1:0]    row_cnt;
  logic [SCNT_W-1:0]   stream_cnt;

  // Strobes decode directly from state so the handshakes stay same-cycle.
  always_comb begin
    in_ready    = (state == IDLE) || (state == LOAD);
    buf_write   = in_valid && in_ready;
    out_valid   = (state == STREAM);
    buf_enable  = out_valid && out_ready;
    out_last    = out_valid && (stream_cnt == STREAM_LAST);
    done        = (state == DONE);
    busy        = (state != IDLE);
    buf_row_ptr = (state == LOAD) ? row_cnt[PTR_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_cnt    <= '0;
      stream_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (buf_write) begin
            row_cnt <= ROW_W'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (buf_write) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == ROW_LAST) begin
              stream_cnt <= '0;
              state      <= STREAM;
            end
          end
        end
        STREAM: begin
          if (buf_enable) begin
            if (out_last) state <= DONE;
            else          stream_cnt <= stream_cnt + 1'b1;
          end
        end
        DONE: begin
          row_cnt    <= '0;
          stream_cnt <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skew_load_controller.sv
// Scoreboard bench for skew_load_controller at ARRAY_SIZE=4: expected strobe
// events are queued by the stimulus and consumed by a negedge monitor.
module tb_skew_load_controller;

  localparam int unsigned N    = 4;
  localparam int unsigned SLEN = 2 * N - 1;

  localparam logic [1:0] EV_WRITE  = 2'd0;
  localparam logic [1:0] EV_ENABLE = 2'd1;
  localparam logic [1:0] EV_DONE   = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [1:0] ptr;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       buf_write;
  logic [1:0] buf_row_ptr;
  logic       buf_enable;
  logic       out_ready;
  logic       out_valid;
  logic       out_last;
  logic       done;
  logic       busy;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   busy_cycles;

  skew_load_controller #(
    .ARRAY_SIZE(N),
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .buf_write  (buf_write),
    .buf_row_ptr(buf_row_ptr),
    .buf_enable (buf_enable),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_ev(input logic [1:0] kind, input logic [1:0] ptr, input logic last);
    exp_t e;
    e.kind = kind;
    e.ptr  = ptr;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic mon_check(input logic [1:0] kind, input logic [1:0] ptr, input logic last);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d ptr=%0d last=%0d, expected none", kind, ptr, last);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.ptr !== ptr || e.last !== last) begin
        bad++;
        $display("FAIL event: got kind=%0d ptr=%0d last=%0d, expected kind=%0d ptr=%0d last=%0d",
                 kind, ptr, last, e.kind, e.ptr, e.last);
      end
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (buf_write === 1'b1 || buf_enable === 1'b1) begin
      total++;
      if (buf_write === 1'b1 && buf_enable === 1'b1) begin
        bad++;
        $display("FAIL strobe_overlap: got buf_write=1 buf_enable=1, expected at most one");
      end
    end
    if (buf_write === 1'b1)  mon_check(EV_WRITE, buf_row_ptr, 1'b0);
    if (buf_enable === 1'b1) mon_check(EV_ENABLE, 2'd0, out_last);
    if (done === 1'b1)       mon_check(EV_DONE, 2'd0, 1'b0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tile();
    for (int unsigned r = 0; r < N; r++) push_ev(EV_WRITE, 2'(r), 1'b0);
    for (int unsigned s = 0; s < SLEN; s++) push_ev(EV_ENABLE, 2'd0, (s == SLEN - 1));
    push_ev(EV_DONE, 2'd0, 1'b0);
  endtask

  // Full tile: optional valid toggling, an optional stall after stall_at
  // enables, and optional in_valid held high through STREAM/DONE.
  task automatic run_tile(input bit toggle, input int stall_at, input int stall_len, input bit hold);
    int  w;
    int  e;
    int  stalled;
    int  guard;
    bit  ph;
    push_tile();
    out_ready = 1'b1;
    w = 0;
    ph = 1'b1;
    guard = 0;
    while (w < int'(N) && guard < 100) begin
      in_valid = toggle ? ph : 1'b1;
      @(posedge clk);
      #1;
      if (in_valid) w++;
      ph = !ph;
      guard++;
    end
    chk("load_budget", 32'(w), 32'(N));
    in_valid = hold;
    #1;
    chk("stream_entry_valid", 32'(out_valid), 32'd1);
    chk("stream_entry_ready", 32'(in_ready), 32'd0);
    e = 0;
    stalled = 0;
    guard = 0;
    while (e < int'(SLEN) && guard < 100) begin
      if (e == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        #1;
        chk("stall_enable", 32'(buf_enable), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_last", 32'(out_last), 32'd0);
      end else begin
        out_ready = 1'b1;
        #1;
        e++;
      end
      if (hold) chk("hold_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      guard++;
    end
    chk("stream_budget", 32'(e), 32'(SLEN));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_enable", 32'(buf_enable), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd0);
    step();
    chk("post_done_busy", 32'(busy), 32'd0);
    chk("post_done_ready", 32'(in_ready), 32'd1);
    if (!hold) in_valid = 1'b0;
  endtask

  // Runs part of a tile, then drops reset asynchronously mid-cycle.
  task automatic partial_then_reset(input int writes, input int enables);
    for (int i = 0; i < writes; i++) push_ev(EV_WRITE, 2'(i), 1'b0);
    for (int i = 0; i < enables; i++) push_ev(EV_ENABLE, 2'd0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < writes + enables; i++) step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_ready", 32'(in_ready), 32'd1);
    chk("async_reset_ptr", 32'(buf_row_ptr), 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    chk("partial_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int start_busy;
    int guard;
    total = 0;
    bad = 0;
    busy_cycles = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_enable", 32'(buf_enable), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_write_idle", 32'(buf_write), 32'd0);
    in_valid = 1'b1;
    #1;
    chk("reset_write_follows_valid", 32'(buf_write), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Straight-through tile: 3 LOAD + 7 STREAM + 1 DONE busy cycles.
    start_busy = busy_cycles;
    run_tile(1'b0, -1, 0, 1'b0);
    chk("busy_cycles", 32'(busy_cycles - start_busy), 32'd11);
    chk("tile1_queue", 32'(exp_q.size()), 32'd0);

    run_tile(1'b1, -1, 0, 1'b0);
    chk("toggle_queue", 32'(exp_q.size()), 32'd0);

    run_tile(1'b0, 3, 5, 1'b0);
    chk("stall_queue", 32'(exp_q.size()), 32'd0);

    run_tile(1'b0, -1, 0, 1'b1);
    run_tile(1'b0, -1, 0, 1'b0);
    chk("hold_queue", 32'(exp_q.size()), 32'd0);

    partial_then_reset(2, 0);
    run_tile(1'b0, -1, 0, 1'b0);
    partial_then_reset(4, 4);
    run_tile(1'b0, -1, 0, 1'b0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
